// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: bus widths, load/store size
// codes, load FSM state encoding, the EXE->MEM and MEM->WB bus layouts
// (declared MSB first) and the address-alignment helper.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int EXE_MEM_BUS_W = 159;
    localparam int MEM_WB_BUS_W  = 124;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic        inst_load;
        logic        inst_store;
        logic [1:0]  ls_size;
        logic        load_sign;
        logic [31:0] store_data;
        logic [31:0] exe_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        wen;
        logic [4:0]  wdest;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        brk;
        logic        fetch_error;
        logic        inst_reserved;
        logic        overflow;
        logic [31:0] pc;
    } exe_mem_bus_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        brk;
        logic        fetch_error;
        logic        inst_reserved;
        logic        raddr_error;
        logic        waddr_error;
        logic        overflow;
        logic [31:0] pc;
    } mem_wb_bus_t;

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [1:0] ls_size,
                                           input logic [1:0] addr_lo);
        return ((ls_size == LS_WORD) && (addr_lo != 2'b00)) ||
               ((ls_size == LS_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_stage_load_align
// Combinational load-data extraction: selects the byte/halfword lane named by
// the low address bits and sign- or zero-extends it; words pass through.
// Ports:
//   rdata_i     raw 32-bit word from RAM (or the hold buffer)
//   addr_lo_i   address bits [1:0]
//   ls_size_i   access size code
//   load_sign_i 1 = sign-extend, 0 = zero-extend
//   result_o    aligned, extended load value
// -----------------------------------------------------------------------------
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  ls_size_i,
    input  logic        load_sign_i,
    output logic [31:0] result_o
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Lane selection and extension
    always_comb begin
        lane_byte_s = 8'h00;
        lane_half_s = 16'h0000;
        result_o    = rdata_i;
        case (addr_lo_i)
            2'b00:   lane_byte_s = rdata_i[7:0];
            2'b01:   lane_byte_s = rdata_i[15:8];
            2'b10:   lane_byte_s = rdata_i[23:16];
            2'b11:   lane_byte_s = rdata_i[31:24];
            default: lane_byte_s = rdata_i[7:0];
        endcase
        if (addr_lo_i[1]) begin
            lane_half_s = rdata_i[31:16];
        end else begin
            lane_half_s = rdata_i[15:0];
        end
        case (ls_size_i)
            LS_BYTE: result_o = {{24{load_sign_i & lane_byte_s[7]}}, lane_byte_s};
            LS_HALF: result_o = {{16{load_sign_i & lane_half_s[15]}}, lane_half_s};
            LS_WORD: result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage: issues data-RAM accesses, detects misaligned accesses,
// waits for synchronous load data (holding it across WB stalls) and builds the
// MEM->WB bus.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   MEM_valid          stage holds a valid instruction
//   EXE_MEM_bus_r      instruction bus from EXE (159 bits)
//   WB_allow_in        WB accepts a new instruction this cycle
//   cancel             flush from WB, kills the in-flight instruction
//   dm_rdata           RAM read data, one cycle after the address
//   dm_addr/wen/wdata  RAM address, byte write enables, write data
//   MEM_over           stage done, bus contents final
//   MEM_WB_bus         instruction bus to WB (124 bits)
//   MEM_wdest          destination register for hazard detection
//   MEM_pc             pc of the instruction in MEM
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     MEM_valid,
    input  logic [EXE_MEM_BUS_W-1:0] EXE_MEM_bus_r,
    input  logic                     WB_allow_in,
    input  logic                     cancel,
    input  logic [31:0]              dm_rdata,
    output logic [31:0]              dm_addr,
    output logic [3:0]               dm_wen,
    output logic [31:0]              dm_wdata,
    output logic                     MEM_over,
    output logic [MEM_WB_BUS_W-1:0]  MEM_WB_bus,
    output logic [4:0]               MEM_wdest,
    output logic [31:0]              MEM_pc
);

    exe_mem_bus_t ex_s;
    mem_wb_bus_t  wb_s;

    logic        misaligned_s;
    logic        raddr_error_s;
    logic        waddr_error_s;
    logic        exc_kill_s;
    logic        load_start_s;
    logic        store_fire_s;
    logic [3:0]  lane_wen_s;
    logic        mem_over_s;
    logic [31:0] load_raw_s;
    logic [31:0] load_data_s;

    mem_state_e  state_q;
    mem_state_e  state_d;
    logic [31:0] load_buf_q;
    logic [31:0] load_buf_d;

    assign ex_s = EXE_MEM_bus_r;

    assign misaligned_s  = is_misaligned(ex_s.ls_size, ex_s.exe_result[1:0]);
    assign raddr_error_s = ex_s.inst_load  & misaligned_s;
    assign waddr_error_s = ex_s.inst_store & misaligned_s;
    assign exc_kill_s    = ex_s.fetch_error | ex_s.inst_reserved | ex_s.overflow |
                           raddr_error_s | waddr_error_s |
                           ex_s.syscall | ex_s.eret | ex_s.brk;

    // Only a clean, uncancelled load needs the RAM round trip; everything
    // else completes in the cycle it arrives.
    assign load_start_s = MEM_valid & ex_s.inst_load  & ~exc_kill_s & ~cancel;
    assign store_fire_s = MEM_valid & ex_s.inst_store & ~exc_kill_s & ~cancel;

    // Store byte enables and lane-replicated write data
    always_comb begin
        lane_wen_s = 4'b0000;
        dm_wdata   = ex_s.store_data;
        case (ex_s.ls_size)
            LS_BYTE: begin
                lane_wen_s = 4'b0001 << ex_s.exe_result[1:0];
                dm_wdata   = {4{ex_s.store_data[7:0]}};
            end
            LS_HALF: begin
                lane_wen_s = ex_s.exe_result[1] ? 4'b1100 : 4'b0011;
                dm_wdata   = {2{ex_s.store_data[15:0]}};
            end
            LS_WORD: begin
                lane_wen_s = 4'b1111;
                dm_wdata   = ex_s.store_data;
            end
            default: begin
                lane_wen_s = 4'b0000;
                dm_wdata   = ex_s.store_data;
            end
        endcase
        if (store_fire_s) begin
            dm_wen = lane_wen_s;
        end else begin
            dm_wen = 4'b0000;
        end
    end

    // Load FSM next state, hold-buffer capture and stage-done flag
    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        mem_over_s = MEM_valid;
        load_raw_s = dm_rdata;
        case (state_q)
            ST_IDLE: begin
                if (load_start_s) begin
                    state_d    = ST_WAIT;
                    mem_over_s = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    mem_over_s = MEM_valid;
                end
            end
            ST_WAIT: begin
                mem_over_s = MEM_valid;
                load_raw_s = dm_rdata;
                if (cancel || WB_allow_in) begin
                    state_d = ST_IDLE;
                end else begin
                    // RAM output is only guaranteed this cycle; keep a copy
                    // for the stall.
                    load_buf_d = dm_rdata;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                mem_over_s = MEM_valid;
                load_raw_s = load_buf_q;
                if (cancel || WB_allow_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_over_s = MEM_valid;
                load_raw_s = dm_rdata;
            end
        endcase
    end

    // Load FSM state and hold buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            load_buf_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
        end
    end

    mem_stage_load_align u_load_align (
        .rdata_i     (load_raw_s),
        .addr_lo_i   (ex_s.exe_result[1:0]),
        .ls_size_i   (ex_s.ls_size),
        .load_sign_i (ex_s.load_sign),
        .result_o    (load_data_s)
    );

    // MEM->WB bus assembly
    always_comb begin
        wb_s               = '0;
        wb_s.wen           = ex_s.wen & ~raddr_error_s;
        wb_s.wdest         = ex_s.wdest;
        if (ex_s.inst_load && !raddr_error_s) begin
            wb_s.mem_result = load_data_s;
        end else begin
            wb_s.mem_result = ex_s.exe_result;
        end
        wb_s.lo_result     = ex_s.lo_result;
        wb_s.hi_write      = ex_s.hi_write;
        wb_s.lo_write      = ex_s.lo_write;
        wb_s.mfhi          = ex_s.mfhi;
        wb_s.mflo          = ex_s.mflo;
        wb_s.mtc0          = ex_s.mtc0;
        wb_s.mfc0          = ex_s.mfc0;
        wb_s.cp0r_addr     = ex_s.cp0r_addr;
        wb_s.syscall       = ex_s.syscall;
        wb_s.eret          = ex_s.eret;
        wb_s.brk           = ex_s.brk;
        wb_s.fetch_error   = ex_s.fetch_error;
        wb_s.inst_reserved = ex_s.inst_reserved;
        wb_s.raddr_error   = raddr_error_s;
        wb_s.waddr_error   = waddr_error_s;
        wb_s.overflow      = ex_s.overflow;
        wb_s.pc            = ex_s.pc;
    end

    assign dm_addr    = ex_s.exe_result;
    assign MEM_over   = mem_over_s;
    assign MEM_WB_bus = wb_s;
    assign MEM_wdest  = ex_s.wdest & {5{MEM_valid}};
    assign MEM_pc     = ex_s.pc;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions, checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         MEM_valid;
    logic [158:0] EXE_MEM_bus_r;
    logic         WB_allow_in;
    logic         cancel;
    logic [31:0]  dm_rdata;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic         MEM_over;
    logic [123:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .WB_allow_in   (WB_allow_in),
        .cancel        (cancel),
        .dm_rdata      (dm_rdata),
        .dm_addr       (dm_addr),
        .dm_wen        (dm_wen),
        .dm_wdata      (dm_wdata),
        .MEM_over      (MEM_over),
        .MEM_WB_bus    (MEM_WB_bus),
        .MEM_wdest     (MEM_wdest),
        .MEM_pc        (MEM_pc)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instruction fields of the current transaction
    logic        f_ld, f_st, f_sgn, f_hiw, f_low, f_wen;
    logic [1:0]  f_sz;
    logic [31:0] f_sd, f_addr, f_lo, f_pc;
    logic [4:0]  f_wdest;
    logic        f_mfhi, f_mflo, f_mtc0, f_mfc0;
    logic [7:0]  f_cp0;
    logic        f_sys, f_eret, f_brk, f_ferr, f_rsv, f_ovf;

    // Observations from the last transaction, for directed checks
    logic [3:0]  obs_wen;
    logic [31:0] obs_wdata, obs_memres;
    logic        obs_rerr, obs_werr, obs_bwen;
    int          obs_lat;

    function automatic logic [158:0] pack_in();
        return {f_ld, f_st, f_sz, f_sgn, f_sd, f_addr, f_lo, f_hiw, f_low, f_wen, f_wdest,
                f_mfhi, f_mflo, f_mtc0, f_mfc0, f_cp0, f_sys, f_eret, f_brk, f_ferr,
                f_rsv, f_ovf, f_pc};
    endfunction

    function automatic logic [123:0] exp_bus(input logic [31:0] memres, input logic rerr,
                                             input logic werr);
        return {f_wen & ~rerr, f_wdest, memres, f_lo, f_hiw, f_low, f_mfhi, f_mflo,
                f_mtc0, f_mfc0, f_cp0, f_sys, f_eret, f_brk, f_ferr, f_rsv, rerr, werr,
                f_ovf, f_pc};
    endfunction

    function automatic logic model_misaligned();
        return (f_sz == 2'd2 && f_addr[1:0] != 2'd0) || (f_sz == 2'd1 && f_addr[0]);
    endfunction

    // Value a load returns from memory word rd
    function automatic logic [31:0] model_load(input logic [31:0] rd);
        int          sh;
        logic [31:0] v;
        if (f_sz == 2'd2) return rd;
        if (f_sz == 2'd0) begin
            sh = 8 * int'(f_addr[1:0]);
            v  = (rd >> sh) & 32'h0000_00FF;
            if (f_sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            sh = 16 * int'(f_addr[1]);
            v  = (rd >> sh) & 32'h0000_FFFF;
            if (f_sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_wen(input logic fire);
        if (!fire) return 4'b0000;
        if (f_sz == 2'd0) return 4'b0001 << f_addr[1:0];
        if (f_sz == 2'd1) return f_addr[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata();
        if (f_sz == 2'd0) return (f_sd & 32'h0000_00FF) * 32'h0101_0101;
        if (f_sz == 2'd1) return (f_sd & 32'h0000_FFFF) * 32'h0001_0001;
        return f_sd;
    endfunction

    task automatic rand_fields(input logic ld, input logic st);
        logic [31:0] r;
        r = $urandom;
        f_ld = ld; f_st = st; f_sz = 2'(r % 3); f_sgn = r[4];
        f_sd = $urandom; f_addr = $urandom; f_lo = $urandom; f_pc = $urandom;
        r = $urandom;
        f_hiw = r[0]; f_low = r[1]; f_wen = r[2]; f_wdest = r[7:3];
        f_mfhi = r[8]; f_mflo = r[9]; f_mtc0 = r[10]; f_mfc0 = r[11]; f_cp0 = r[19:12];
        f_sys  = ($urandom % 16) == 0;
        f_eret = ($urandom % 16) == 0;
        f_brk  = ($urandom % 16) == 0;
        f_ferr = ($urandom % 16) == 0;
        f_rsv  = ($urandom % 16) == 0;
        f_ovf  = ($urandom % 16) == 0;
    endtask

    task automatic set_mem(input logic ld, input logic st, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] sd, input logic [31:0] addr);
        rand_fields(ld, st);
        f_sz = sz; f_sgn = sgn; f_sd = sd; f_addr = addr;
        f_sys = 1'b0; f_eret = 1'b0; f_brk = 1'b0; f_ferr = 1'b0; f_rsv = 1'b0; f_ovf = 1'b0;
    endtask

    // One instruction through MEM. Entered and left #1 after a rising edge.
    // stall: cycles WB refuses after load data arrives; c0: cancel on arrival;
    // cw: cancel in the first data cycle; rd0: memory word returned for a load.
    task automatic run_txn(input int stall, input logic c0, input logic cw,
                           input logic [31:0] rd0);
        logic         rerr, werr, kill, live, fire;
        logic [123:0] got_b, exp_b;
        rerr = f_ld & model_misaligned();
        werr = f_st & model_misaligned();
        kill = f_ferr | f_rsv | f_ovf | rerr | werr | f_sys | f_eret | f_brk;
        live = f_ld & ~kill & ~c0;
        fire = f_st & ~kill & ~c0;
        MEM_valid = 1'b1; EXE_MEM_bus_r = pack_in(); cancel = c0;
        WB_allow_in = 1'b1; dm_rdata = $urandom;
        @(negedge clk);
        obs_wen = dm_wen; obs_wdata = dm_wdata;
        obs_rerr = MEM_WB_bus[34]; obs_werr = MEM_WB_bus[33]; obs_bwen = MEM_WB_bus[123];
        obs_lat = MEM_over ? 1 : 0;
        obs_memres = MEM_WB_bus[117:86];
        chk("dm_addr", 128'(dm_addr), 128'(f_addr));
        chk("MEM_wdest", 128'(MEM_wdest), 128'(f_wdest));
        chk("MEM_pc", 128'(MEM_pc), 128'(f_pc));
        chk("dm_wen", 128'(dm_wen), 128'(model_wen(fire)));
        if (fire) chk("dm_wdata", 128'(dm_wdata), 128'(model_wdata()));
        if (live) begin
            chk("over_load_issue", 128'(MEM_over), 128'(1'b0));
        end else begin
            chk("over_single", 128'(MEM_over), 128'(1'b1));
            got_b = MEM_WB_bus;
            exp_b = exp_bus(f_addr, rerr, werr);
            if (f_ld && !rerr) begin
                // killed load: data source is irrelevant, compare the rest
                got_b[117:86] = 32'h0;
                exp_b[117:86] = 32'h0;
            end
            chk("bus_single", 128'(got_b), 128'(exp_b));
        end
        @(posedge clk); #1;
        if (live) begin
            dm_rdata = rd0; cancel = cw; WB_allow_in = (stall == 0);
            for (int k = 0; k <= stall; k++) begin
                @(negedge clk);
                if (k == 0 && MEM_over && obs_lat == 0) obs_lat = 2;
                obs_memres = MEM_WB_bus[117:86];
                chk("over_load_done", 128'(MEM_over), 128'(1'b1));
                chk("bus_load", 128'(MEM_WB_bus), 128'(exp_bus(model_load(rd0), 1'b0, 1'b0)));
                @(posedge clk); #1;
                if (cw) break;
                dm_rdata = $urandom;
                WB_allow_in = (k + 1 == stall);
            end
        end
        MEM_valid = 1'b0; cancel = 1'b0; WB_allow_in = 1'b1;
    endtask

    task automatic idle_cycle();
        logic [31:0] r;
        r = $urandom;
        rand_fields(r[0], r[1]);
        MEM_valid = 1'b0; EXE_MEM_bus_r = pack_in(); cancel = r[2]; WB_allow_in = r[3];
        @(negedge clk);
        chk("idle_over", 128'(MEM_over), 128'(1'b0));
        chk("idle_wen", 128'(dm_wen), 128'(4'b0000));
        chk("idle_wdest", 128'(MEM_wdest), 128'(5'd0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        resetn = 1'b0; MEM_valid = 1'b0; WB_allow_in = 1'b1; cancel = 1'b0;
        dm_rdata = 32'h0; rand_fields(1'b0, 1'b1); EXE_MEM_bus_r = pack_in();
        @(negedge clk); @(negedge clk);
        chk("rst_over", 128'(MEM_over), 128'(1'b0));
        chk("rst_wen", 128'(dm_wen), 128'(4'b0000));
        chk("rst_wdest", 128'(MEM_wdest), 128'(5'd0));
        @(posedge clk); #1;
        resetn = 1'b1;
        idle_cycle();

        // SB lane 2
        set_mem(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 32'h0000_1002);
        run_txn(0, 1'b0, 1'b0, 32'h0);
        chk("sb_wen", 128'(obs_wen), 128'(4'b0100));
        chk("sb_wdata", 128'(obs_wdata), 128'(32'hABAB_ABAB));
        chk("sb_lat", 128'(obs_lat), 128'(1));

        // LB / LBU from lane 3
        set_mem(1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_1003);
        run_txn(0, 1'b0, 1'b0, 32'h80FF_1234);
        chk("lb_lat", 128'(obs_lat), 128'(2));
        chk("lb_data", 128'(obs_memres), 128'(32'hFFFF_FF80));
        set_mem(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_1003);
        run_txn(0, 1'b0, 1'b0, 32'h80FF_1234);
        chk("lbu_data", 128'(obs_memres), 128'(32'h0000_0080));

        // LW with a 3-cycle WB stall; RAM output changes while held
        set_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_1000);
        run_txn(3, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("lw_hold_data", 128'(obs_memres), 128'(32'hDEAD_BEEF));

        // Misaligned LW and SH
        set_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_1002);
        f_wen = 1'b1;
        run_txn(0, 1'b0, 1'b0, 32'h0);
        chk("lw_mis_rerr", 128'(obs_rerr), 128'(1'b1));
        chk("lw_mis_wen", 128'(obs_bwen), 128'(1'b0));
        chk("lw_mis_lat", 128'(obs_lat), 128'(1));
        set_mem(1'b0, 1'b1, 2'd1, 1'b0, 32'h1234_5678, 32'h0000_1001);
        run_txn(0, 1'b0, 1'b0, 32'h0);
        chk("sh_mis_werr", 128'(obs_werr), 128'(1'b1));
        chk("sh_mis_dmwen", 128'(obs_wen), 128'(4'b0000));

        // Cancel while waiting for data, then a fresh load must start from idle
        set_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_2000);
        run_txn(2, 1'b0, 1'b1, 32'h1111_2222);
        set_mem(1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000_2002);
        run_txn(0, 1'b0, 1'b0, 32'h8001_7FFF);
        chk("after_cancel_lat", 128'(obs_lat), 128'(2));
        chk("after_cancel_data", 128'(obs_memres), 128'(32'hFFFF_8001));

        // Asynchronous reset while holding load data
        set_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_3000);
        MEM_valid = 1'b1; EXE_MEM_bus_r = pack_in(); WB_allow_in = 1'b0; cancel = 1'b0;
        @(posedge clk); #1;
        dm_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dm_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("hold_over", 128'(MEM_over), 128'(1'b1));
        chk("hold_data", 128'(MEM_WB_bus[117:86]), 128'(32'h1234_5678));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_state", 128'(dut.state_q), 128'(2'b00));
        chk("arst_buf", 128'(dut.load_buf_q), 128'(32'h0));
        chk("arst_over", 128'(MEM_over), 128'(1'b0));
        chk("arst_dmwen", 128'(dm_wen), 128'(4'b0000));
        @(posedge clk); #1;
        resetn = 1'b1; MEM_valid = 1'b0; WB_allow_in = 1'b1;
        set_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_3004);
        run_txn(0, 1'b0, 1'b0, 32'hCAFE_0001);
        chk("post_rst_lat", 128'(obs_lat), 128'(2));

        // Randomized mix of loads, stores, other instructions, stalls, cancels
        for (int t = 0; t < 300; t++) begin
            r = $urandom;
            rand_fields(r[1:0] < 2'd2, r[1:0] == 2'd2);
            if (r[4:2] == 3'd0) idle_cycle();
            run_txn(int'(r[7:6]), (r[11:8] == 4'd0), (r[14:12] == 3'd0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
